// File: rtl/pong_uart_pkg.sv
// pong_uart_pkg: constants and types shared by the pong UART blocks
// (uart_rx, uart_tx, uart_tx_arbiter).
package pong_uart_pkg;

  localparam int unsigned CLK_FREQ_HZ  = 65_000_000;
  localparam int unsigned BAUD_RATE    = 115_200;
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  // Upper nibble of every packet header byte
  localparam logic [3:0] HDR_SYNC = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The search starts at ptr
// and wraps; gnt is one-hot (all zero when req is zero), idx its index.
module rr_arbiter
  import pong_uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  logic [PTR_W:0] cand;
  logic           found;

  // Walk ptr, ptr+1, ... modulo NUM_REQ; first requester found wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && req[cand[PTR_W-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[PTR_W-1:0]]  = 1'b1;
        idx                   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide uart_tx among NUM_REQ requesters.
// Packet = header {HDR_SYNC, id} followed by payload bytes MSB first.
// Define UART_ARB_CHECKSUM_EN to append an XOR checksum byte.
module uart_tx_arbiter
  import pong_uart_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned PAYLOAD_BYTES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*PAYLOAD_BYTES*8-1:0] payload,
  output logic [NUM_REQ-1:0]                grant,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy,
  output logic                              busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(PAYLOAD_BYTES + 2);
  localparam int unsigned PL_W  = PAYLOAD_BYTES * 8;
`ifdef UART_ARB_CHECKSUM_EN
  localparam int unsigned PKT_BYTES = PAYLOAD_BYTES + 2;
`else
  localparam int unsigned PKT_BYTES = PAYLOAD_BYTES + 1;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_BYTES - 1);

  arb_state_t             state, state_nxt;
  logic [PTR_W-1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0]       byte_cnt, cnt_nxt;
  logic [PKT_BYTES*8-1:0] byte_buf, pkt_new;
  logic [PL_W-1:0]        sel_payload;
  logic [NUM_REQ-1:0]     arb_gnt, grant_nxt;
  logic [PTR_W-1:0]       arb_idx;
  logic [7:0]             data_nxt;
  logic                   start_nxt, busy_nxt, load_pkt;
`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Assemble the packet of the current arbitration winner, byte k at [k*8 +: 8]
  always_comb begin
    sel_payload  = payload[arb_idx*PL_W +: PL_W];
    pkt_new      = '0;
    pkt_new[7:0] = {HDR_SYNC, 4'(arb_idx)};
    for (int unsigned b = 0; b < PAYLOAD_BYTES; b++) begin
      pkt_new[(b+1)*8 +: 8] = sel_payload[(PAYLOAD_BYTES-1-b)*8 +: 8];
    end
`ifdef UART_ARB_CHECKSUM_EN
    csum = pkt_new[7:0];
    for (int unsigned b = 0; b < PAYLOAD_BYTES; b++) begin
      csum = csum ^ sel_payload[b*8 +: 8];
    end
    pkt_new[(PKT_BYTES-1)*8 +: 8] = csum;
`endif
  end

  // Next state and next values of the registered outputs.
  // Outputs are registered, so the tx_start pulse decided in SEND
  // appears on the cycle after SEND.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = byte_cnt;
    data_nxt  = tx_data;
    busy_nxt  = busy;
    grant_nxt = '0;
    start_nxt = 1'b0;
    load_pkt  = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0 && !tx_busy) begin
          grant_nxt = arb_gnt;
          load_pkt  = 1'b1;
          data_nxt  = pkt_new[7:0];
          cnt_nxt   = '0;
          ptr_nxt   = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
          busy_nxt  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        start_nxt = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_cnt == LAST_IDX) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = byte_cnt + CNT_W'(1);
            data_nxt  = byte_buf[cnt_nxt*8 +: 8];
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs, counters and the latched packet buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      byte_cnt <= '0;
      byte_buf <= '0;
    end else begin
      grant    <= grant_nxt;
      tx_start <= start_nxt;
      tx_data  <= data_nxt;
      busy     <= busy_nxt;
      ptr      <= ptr_nxt;
      byte_cnt <= cnt_nxt;
      if (load_pkt) byte_buf <= pkt_new;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed plus randomized checks of uart_tx_arbiter
// against a packet/round-robin reference model and a uart_tx stand-in.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned PB = 2;
`ifdef UART_ARB_CHECKSUM_EN
  localparam int unsigned PKT = PB + 2;
`else
  localparam int unsigned PKT = PB + 1;
`endif
  localparam int unsigned IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*PB*8-1:0] payload;
  logic [N-1:0]      grant;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              busy;
  logic              uart_busy = 1'b0;
  logic              force_busy = 1'b0;
  int unsigned       ucnt = 0;
  int unsigned       cyc = 0;
  logic              prev_txb = 1'b0;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;
  int          mptr   = 0;
  logic [7:0]  sent_q[$];
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  int unsigned fall_q[$];
  int          order_q[$];

  always #5 clk = ~clk;

  assign tx_busy = uart_busy | force_busy;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .PAYLOAD_BYTES (PB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .payload  (payload),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .busy     (busy)
  );

  // uart_tx stand-in: busy rises the cycle after tx_start, lasts 20 cycles
  always @(posedge clk) begin
    if (tx_start) begin
      uart_busy <= 1'b1;
      ucnt      <= 19;
    end else if (uart_busy) begin
      if (ucnt == 0) uart_busy <= 1'b0;
      else           ucnt <= ucnt - 1;
    end
  end

  // Log transmitted bytes, tx_start cycles and tx_busy falling cycles
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_txb <= tx_busy;
    if (tx_start) begin
      sent_q.push_back(tx_data);
      start_q.push_back(cyc);
    end
    if (prev_txb && !tx_busy) fall_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] m);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (p + k) % N;
      if (m[IW'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[IW'(w)] = 1'b1;
    return r;
  endfunction

  task automatic push_expected(input int id);
    logic [7:0]      pkt [PB+2];
    logic [PB*8-1:0] pl;
    pl          = payload[id*PB*8 +: PB*8];
    pkt[0]      = {4'hA, 4'(id)};
    pkt[PB+1]   = pkt[0];
    for (int b = 0; b < PB; b++) begin
      pkt[b+1]  = pl[(PB-1-b)*8 +: 8];
      pkt[PB+1] = pkt[PB+1] ^ pkt[b+1];
    end
    for (int k = 0; k < PKT; k++) exp_q.push_back(pkt[k]);
  endtask

  // Called on the cycle a grant is visible: check the winner, record the
  // expected packet, then scramble the winner's payload.
  task automatic on_grant();
    int w;
    w = rr_pick(mptr, req);
    check("grant_rr", 32'(grant), 32'(onehot(w)));
    if (w >= 0) begin
      mptr = (w + 1) % N;
      order_q.push_back(w);
      push_expected(w);
      payload[w*PB*8 +: PB*8] = (PB*8)'($urandom);
    end
  endtask

  task automatic wait_grant(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    do begin tick(); n++; end while (grant == '0 && n < budget);
    check({tag, "_grant_seen"}, 32'(grant != '0), 32'(1));
  endtask

  task automatic wait_quiet(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    do begin tick(); n++; end while ((busy || uart_busy) && n < budget);
    check({tag, "_quiet"}, 32'(busy), 32'(0));
  endtask

  task automatic clear_logs();
    sent_q.delete(); exp_q.delete(); start_q.delete(); fall_q.delete();
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
    clear_logs();
  endtask

  task automatic serve(input int unsigned n, input bit random_mode);
    int unsigned  got, cycles;
    logic [N-1:0] raise;
    got = 0; cycles = 0; raise = '0;
    while (got < n && cycles < 5000) begin
      tick(); cycles++;
      if (grant != '0) begin
        on_grant();
        req   = req & ~grant;
        raise = random_mode ? N'($urandom_range(1, (1 << N) - 1)) : grant;
        got++;
      end else if (raise != '0) begin
        req   = req | raise;
        raise = '0;
      end
    end
    check("serve_grants", 32'(got), 32'(n));
    req = '0;
    wait_quiet("serve", 2000);
  endtask

  initial begin
    int          exp_order [4];
    int unsigned n_grant, n0, guard;
    exp_order = '{0, 1, 2, 0};

    // Reset values
    rst = 1'b1; req = '0; payload = {$urandom, $urandom};
    repeat (3) tick();
    check("rst_grant",    32'(grant),        32'(0));
    check("rst_tx_start", 32'(tx_start),     32'(0));
    check("rst_tx_data",  32'(tx_data),      32'(0));
    check("rst_busy",     32'(busy),         32'(0));
    check("rst_ptr",      32'(dut.ptr),      32'(0));
    check("rst_byte_cnt", 32'(dut.byte_cnt), 32'(0));
    rst = 1'b0;
    tick();

    // Contention from reset: all requesters, re-raised after each grant
    clear_logs(); order_q.delete();
    req = '1;
    serve(4, 1'b0);
    check("contention_count", 32'(order_q.size()), 32'(4));
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check($sformatf("contention_order%0d", i), 32'(order_q[i]), 32'(exp_order[i]));
    compare_stream("contention");

    // Single request with fixed payload, latency and inter-byte timing
    payload[1*PB*8 +: PB*8] = 16'h1234;
    req = 3'b010;
    tick();
    check("single_grant", 32'(grant), 32'(3'b010));
    check("single_busy",  32'(busy),  32'(1));
    on_grant();
    req = '0;
    tick();
    check("single_grant_pulse", 32'(grant),    32'(0));
    check("single_tx_start",    32'(tx_start), 32'(1));
    check("single_header",      32'(tx_data),  32'(8'hA1));
    wait_quiet("single", 500);
    check("single_start_count", 32'(start_q.size()), 32'(PKT));
    for (int k = 1; k < PKT && k < start_q.size() && k <= fall_q.size(); k++)
      check($sformatf("single_gap%0d", k), 32'(start_q[k] - fall_q[k-1]), 32'(2));
    if (sent_q.size() >= 3) begin
      check("single_b1", 32'(sent_q[1]), 32'(8'h12));
      check("single_b2", 32'(sent_q[2]), 32'(8'h34));
    end
`ifdef UART_ARB_CHECKSUM_EN
    if (sent_q.size() >= 4) check("single_csum", 32'(sent_q[3]), 32'(8'h87));
`endif
    compare_stream("single");

    // Blocked start: tx_busy held high keeps requests pending
    force_busy = 1'b1;
    tick();
    req = 3'b001;
    n_grant = 0;
    repeat (10) begin tick(); if (grant != '0) n_grant++; end
    check("blocked_no_grant", 32'(n_grant), 32'(0));
    check("blocked_busy",     32'(busy),    32'(0));
    force_busy = 1'b0;
    tick();
    check("blocked_grant_after_fall", 32'(grant), 32'(3'b001));
    on_grant();
    req = '0;
    wait_quiet("blocked", 500);
    compare_stream("blocked");

    // Withdrawal: req[2] pulsed while packet 0 is in flight
    req = 3'b001;
    wait_grant("withdraw", 50);
    on_grant();
    req = '0;
    repeat (5) tick();
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    wait_quiet("withdraw", 500);
    n_grant = 0;
    repeat (30) begin tick(); if (grant != '0) n_grant++; end
    check("withdraw_no_grant", 32'(n_grant), 32'(0));
    n0 = 0;
    foreach (sent_q[i]) if (sent_q[i] == 8'hA2) n0++;
    check("withdraw_no_a2", 32'(n0), 32'(0));
    compare_stream("withdraw");

    // Reset in WAIT_DONE of byte 1
    req = 3'b010;
    wait_grant("midrst", 50);
    on_grant();
    req = '0;
    guard = 0;
    while (start_q.size() < 2 && guard < 200) begin tick(); guard++; end
    check("midrst_byte1_started", 32'(start_q.size() >= 2), 32'(1));
    repeat (3) tick();
    check("midrst_byte_cnt", 32'(dut.byte_cnt), 32'(1));
    rst = 1'b1;
    tick();
    check("midrst_tx_start", 32'(tx_start), 32'(0));
    check("midrst_busy",     32'(busy),     32'(0));
    check("midrst_grant",    32'(grant),    32'(0));
    check("midrst_ptr",      32'(dut.ptr),  32'(0));
    check("midrst_tx_data",  32'(tx_data),  32'(0));
    rst  = 1'b0;
    mptr = 0;
    n0 = start_q.size();
    repeat (25) tick();
    check("midrst_no_start", 32'(start_q.size() - n0), 32'(0));
    clear_logs();
    req = 3'b100;
    wait_grant("midrst_next", 100);
    on_grant();
    req = '0;
    wait_quiet("midrst_next", 500);
    if (sent_q.size() > 0) check("midrst_first_hdr", 32'(sent_q[0]), 32'(8'hA2));
    compare_stream("midrst_next");

    // Randomized traffic
    payload = {$urandom, $urandom};
    req = N'($urandom_range(1, (1 << N) - 1));
    serve(6, 1'b1);
    compare_stream("random");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one byte-wide UART transmitter among several game-logic requesters, such as the paddle, ball and score updaters. Each requester posts a fixed-length payload. The block frames it as a header byte followed by payload bytes, sequences the bytes into the UART transmitter through a start/busy handshake, and acknowledges the requester with a grant pulse. It sits between the game-state logic and the uart_tx instance on the same 65 MHz clk domain as the UART receive path.

## Interface
- NUM_REQ, 3: number of requesters; legal range 2..16.
- PAYLOAD_BYTES, 2: payload bytes per packet; legal range 1..8.
- clk  in  1  system clock, 65 MHz.
- rst  in  1  reset: synchronous, active-high.
- req  in  NUM_REQ  per-requester request level; held high until the matching grant.
- payload  in  NUM_REQ*PAYLOAD_BYTES*8  requester i occupies slice [i*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8]; most significant byte is sent first.
- grant  out  NUM_REQ  one-hot, one-cycle pulse when requester i's payload is latched.
- tx_data  out  8  byte to transmit; stable from the SEND cycle until the byte completes.
- tx_start  out  1  one-cycle pulse to uart_tx.
- tx_busy  in  1  uart_tx busy: rises the cycle after tx_start, falls after the stop bit.
- busy  out  1  high while a packet is in flight, from the grant cycle through the last byte done.

## Operation
- Packet framing:
  - Byte 0 is the header {4'hA, id[3:0]}, where id is the granted requester index.
  - The payload bytes follow, MSB first.
  - With checksum disabled, a packet is 1+PAYLOAD_BYTES bytes.
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Arbitration runs only when req != 0 and tx_busy == 0.
  - The round-robin search starts at index ptr.
  - The winner w gets a grant[w] pulse on the next cycle.
  - On that same cycle the block latches the header and payload into a byte buffer, sets tx_data to the header, sets byte_cnt to 0, updates ptr to (w+1) mod NUM_REQ, and moves to SEND.
- SEND: tx_start = 1 for exactly one cycle, then move to WAIT_ACK.
- WAIT_ACK: stay until tx_busy == 1, then move to WAIT_DONE.
- WAIT_DONE: stay until tx_busy == 0. Then:
  - If byte_cnt is the last index, move to IDLE and clear busy.
  - Otherwise increment byte_cnt, load the next byte into tx_data and move to SEND.
- Requests:
  - Only requesters with req high on the arbitration cycle are eligible.
  - Dropping req before the grant withdraws the request; no grant is issued.
  - Payload changes after the grant have no effect on the packet being sent.
- byte_cnt is $clog2(PAYLOAD_BYTES+2) bits wide and never exceeds the last index.
- ptr is $clog2(NUM_REQ) bits wide and wraps from NUM_REQ-1 to 0.

## Timing
- Reset values: state = IDLE, grant = 0, tx_start = 0, tx_data = 8'h00, busy = 0, ptr = 0, byte_cnt = 0.
- All outputs are registered.
- Request to first tx_start: req is seen in IDLE at cycle N; grant and busy are high at N+1; tx_start is high at N+2.
- Between bytes: tx_busy falls at cycle M; the next tx_start fires at M+2.
- Packet done: busy goes low on the cycle after the final tx_busy fall. Arbitration is legal on that same cycle, so a new grant can follow one cycle later.
- Reset mid-packet: the block returns to the reset values on the next edge with no further tx_start. A byte already in uart_tx is not aborted by this block.
- tx_busy high while in IDLE blocks arbitration. Requests pend without loss.

## Configuration
- UART_ARB_CHECKSUM_EN defined:
  - Append one checksum byte: the XOR of the header and all payload bytes.
  - Packet length becomes 2+PAYLOAD_BYTES bytes.
  - The checksum is accumulated while bytes are latched, not on the fly during transmission.
- UART_ARB_CHECKSUM_EN undefined: no checksum byte and no XOR logic.

## Structure
- Shared package pong_uart_pkg holds:
  - the header nibble constant HDR_SYNC = 4'hA;
  - the FSM state enum typedef;
  - the clock frequency and baud constants shared with uart_rx/uart_tx.
- Sub-module rr_arbiter(NUM_REQ):
  - inputs: req, ptr;
  - outputs: one-hot gnt and encoded index;
  - purely combinational.
- Byte buffer, counters and FSM live in uart_tx_arbiter.

## Test plan
- Behavioural uart_tx model: tx_busy rises one cycle after tx_start and lasts 20 cycles.
- Single request, checksum on: req = 3'b010, payload[1] = 16'h1234 -> tx_data sequence A1, 12, 34, 87; grant = 3'b010 for one cycle; exactly 4 tx_start pulses. With checksum off, the sequence is A1, 12, 34.
- Contention from reset: req = 3'b111 held, re-raised after each grant -> grant order 0, 1, 2, 0, with no interleaving of bytes between packets.
- Withdrawal: req[2] pulsed for 1 cycle while packet 0 is in flight -> no grant[2] and no header A2 sent.
- Blocked start: tx_busy forced high, then req = 3'b001 -> no grant until tx_busy falls; grant arrives 1 cycle after the fall.
- Reset mid-packet: rst asserted in WAIT_DONE of byte 1 -> next cycle tx_start = 0, busy = 0, ptr = 0. A following req = 3'b100 produces header A2 as the first byte.
